// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Pipeline hazard controller with a shadow E/M/W scoreboard, D-stage
//           stall/forward generation and mult/div busy sequencing.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_rs_used,
  input  logic       D_rt_used,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_Tnew,
  input  logic [1:0] D_md_start,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic       md_busy
);

  localparam int         CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int         CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;

  logic [4:0]       e_dst_q, e_dst_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic [1:0]       e_md_q, e_md_d;
  logic [4:0]       m_dst_q, m_dst_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       w_dst_q, w_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_rs, stall_rt, stall_md;

  function automatic logic src_hazard(
    input logic       used,
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    return used && (r != 5'd0) &&
           (((r == e_dst) && (tuse < e_tnew)) || ((r == m_dst) && (tuse < m_tnew)));
  endfunction

  // The youngest matching producer owns the register; if it is not ready yet
  // older copies are stale, so the select stays at 0 and the stall covers it.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew,
    input logic [4:0] w_dst
  );
    if (r == 5'd0)        return 2'd0;
    else if (r == e_dst)  return (e_tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (r == m_dst)  return (m_tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (r == w_dst)  return 2'd3;
    else                  return 2'd0;
  endfunction

  always_comb begin
    stall_rs = src_hazard(D_rs_used, D_rs, D_Tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    stall_rt = src_hazard(D_rt_used, D_rt, D_Tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    md_busy  = (cnt_q != '0) || (e_md_q != MD_NONE);
    stall_md = md_busy && (D_md_use || (D_md_start != MD_NONE));
    stall    = stall_rs || stall_rt || stall_md;
    fwd_rs_D = fwd_sel(D_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
    fwd_rt_D = fwd_sel(D_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q);
  end

  always_comb begin
    e_dst_d  = stall ? 5'd0 : D_dst;
    e_tnew_d = stall ? 2'd0 : D_Tnew;
    e_md_d   = stall ? MD_NONE : D_md_start;
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    w_dst_d  = m_dst_q;
    cnt_d    = cnt_q;
    // A start leaving E reloads; anything other than mult is timed as div.
    if (e_md_q == MD_MULT)
      cnt_d = CNT_W'(MULT_CYCLES);
    else if (e_md_q != MD_NONE)
      cnt_d = CNT_W'(DIV_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_md_q   <= MD_NONE;
      m_dst_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      w_dst_q  <= 5'd0;
      cnt_q    <= '0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_md_q   <= e_md_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl against a pipeline-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic       D_rs_used, D_rt_used, D_md_use;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew, D_md_start;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_used(D_rs_used), .D_rt_used(D_rt_used),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_dst(D_dst), .D_Tnew(D_Tnew),
    .D_md_start(D_md_start), .D_md_use(D_md_use),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: each in-flight instruction keeps its Tnew as seen at E entry; its
  // readiness later is derived from how far it has travelled. Mult/div busy is
  // tracked as the last absolute cycle number the unit is occupied.
  logic [4:0] me_dst, mm_dst, mw_dst;
  int         me_tnew, mm_tnew;
  logic [1:0] me_md;
  int         cyc = 0;
  int         busy_until = -1;

  function automatic int remaining(input int tnew_at_e, input int stages_past_e);
    return (tnew_at_e > stages_past_e) ? tnew_at_e - stages_past_e : 0;
  endfunction

  function automatic logic exp_busy();
    return (me_md != 2'b00) || (cyc <= busy_until);
  endfunction

  function automatic logic reads_late(input logic used, input logic [4:0] r, input logic [1:0] tuse);
    if (!used || r == 5'd0) return 1'b0;
    if (r == me_dst && int'(tuse) < remaining(me_tnew, 0)) return 1'b1;
    if (r == mm_dst && int'(tuse) < remaining(mm_tnew, 1)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_stall();
    return reads_late(D_rs_used, D_rs, D_Tuse_rs) || reads_late(D_rt_used, D_rt, D_Tuse_rt) ||
           (exp_busy() && (D_md_use || D_md_start != 2'b00));
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (r == me_dst) return (remaining(me_tnew, 0) == 0) ? 2'd1 : 2'd0;
    if (r == mm_dst) return (remaining(mm_tnew, 1) == 0) ? 2'd2 : 2'd0;
    if (r == mw_dst) return 2'd3;
    return 2'd0;
  endfunction

  task automatic tick();
    logic bubble;
    @(posedge clk);
    bubble = exp_stall();
    if (reset) begin
      me_dst = 0; mm_dst = 0; mw_dst = 0;
      me_tnew = 0; mm_tnew = 0; me_md = 2'b00;
      busy_until = -1;
    end else begin
      if (me_md == 2'b01)      busy_until = cyc + MULT_CYCLES;
      else if (me_md != 2'b00) busy_until = cyc + DIV_CYCLES;
      mw_dst = mm_dst;
      mm_dst = me_dst; mm_tnew = me_tnew;
      me_dst  = bubble ? 5'd0 : D_dst;
      me_tnew = bubble ? 0 : int'(D_Tnew);
      me_md   = bubble ? 2'b00 : D_md_start;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] rs, input logic rsu, input logic [1:0] tus,
                       input logic [4:0] rt, input logic rtu, input logic [1:0] tut,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic [1:0] mds, input logic mdu);
    D_rs = rs; D_rs_used = rsu; D_Tuse_rs = tus;
    D_rt = rt; D_rt_used = rtu; D_Tuse_rt = tut;
    D_dst = dst; D_Tnew = tnew; D_md_start = mds; D_md_use = mdu;
    #1;
  endtask

  task automatic nop();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    nop();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    drive(5'd3, 1'b1, 2'd0, 5'd4, 1'b1, 2'd0, 5'd0, 2'd0, 2'b00, 1'b1);
    n_cmp++; if (stall !== 1'b0)    begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (fwd_rs_D !== 2'd0) begin n_err++; $display("FAIL reset_fwd_rs got %0d want 0", fwd_rs_D); end
    n_cmp++; if (fwd_rt_D !== 2'd0) begin n_err++; $display("FAIL reset_fwd_rt got %0d want 0", fwd_rt_D); end
    n_cmp++; if (md_busy !== 1'b0)  begin n_err++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8, 2'd2, 2'b00, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_issue_stall got %b want 0", stall); end
    tick();
    drive(5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 5'd10, 2'd1, 2'b00, 1'b0);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_use_stall got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_use_release got %b want 0", stall); end
    n_cmp++; if (fwd_rs_D !== exp_fwd(D_rs)) begin n_err++; $display("FAIL load_use_fwd got %0d want %0d", fwd_rs_D, exp_fwd(D_rs)); end
    tick();
  endtask

  task automatic test_alu_b2b();
    for (int tu = 0; tu < 2; tu++) begin
      nop(); tick(); tick(); tick();
      drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd9, 2'd1, 2'b00, 1'b0);
      tick();
      drive(5'd0, 1'b0, 2'd0, 5'd9, 1'b1, 2'(tu), 5'd0, 2'd0, 2'b00, 1'b0);
      n_cmp++; if (stall !== (tu == 0)) begin n_err++; $display("FAIL alu_b2b_stall tuse=%0d got %b want %b", tu, stall, tu == 0); end
      n_cmp++; if (fwd_rt_D !== 2'd0) begin n_err++; $display("FAIL alu_b2b_fwd0 tuse=%0d got %0d want 0", tu, fwd_rt_D); end
      tick();
      if (tu == 0) begin
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL alu_b2b_release got %b want 0", stall); end
        n_cmp++; if (fwd_rt_D !== 2'd2) begin n_err++; $display("FAIL alu_b2b_fwd_m got %0d want 2", fwd_rt_D); end
      end else begin
        n_cmp++; if (fwd_rt_D !== 2'd2) begin n_err++; $display("FAIL alu_b2b_next_fwd got %0d want 2", fwd_rt_D); end
      end
      tick();
    end
  endtask

  task automatic test_zero_dst();
    nop(); tick(); tick();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd2, 2'b00, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
      n_cmp++;
      if (stall !== 1'b0 || fwd_rs_D !== 2'd0 || fwd_rt_D !== 2'd0) begin
        n_err++; $display("FAIL zero_reg cyc%0d got stall=%b rs=%0d rt=%0d want 0/0/0", i, stall, fwd_rs_D, fwd_rt_D);
      end
      tick();
    end
  endtask

  task automatic test_mult_mflo();
    int nst;
    nop(); tick();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 2'b01, 1'b0);
    n_cmp++; if (md_busy !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL mult_issue got busy=%b stall=%b want 0/0", md_busy, stall); end
    tick();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd2, 2'd1, 2'b00, 1'b1);
    n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_rise got %b want 1", md_busy); end
    nst = 0;
    for (int i = 0; i < 20; i++) begin
      if (stall !== 1'b1) break;
      nst++;
      tick();
    end
    n_cmp++; if (nst !== 1 + MULT_CYCLES) begin n_err++; $display("FAIL mflo_hold got %0d cycles want %0d", nst, 1 + MULT_CYCLES); end
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_fall got %b want 0", md_busy); end
    tick();
  endtask

  task automatic test_back_to_back_div();
    int nst, nbusy;
    nop(); tick();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0, 2'b10, 1'b0);
    tick();
    nst = 0;
    for (int i = 0; i < 30; i++) begin
      if (stall !== 1'b1) break;
      nst++;
      n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL div_hold_busy cyc%0d got %b want 1", i, md_busy); end
      tick();
    end
    n_cmp++; if (nst !== 1 + DIV_CYCLES) begin n_err++; $display("FAIL div_div_hold got %0d cycles want %0d", nst, 1 + DIV_CYCLES); end
    tick();
    nop();
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      if (md_busy !== 1'b1) break;
      nbusy++;
      tick();
    end
    n_cmp++; if (nbusy !== 1 + DIV_CYCLES) begin n_err++; $display("FAIL div2_busy got %0d cycles want %0d", nbusy, 1 + DIV_CYCLES); end
  endtask

  task automatic test_reset_mid_div();
    nop(); tick();
    drive(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 2'd1, 2'b10, 1'b0);
    tick();
    nop();
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mid_div_busy got %b want 1", md_busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'd5, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 5'd6, 2'd1, 2'b00, 1'b1);
    n_cmp++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || fwd_rs_D !== 2'd0 || fwd_rt_D !== 2'd0) begin
      n_err++; $display("FAIL reset_mid_div got busy=%b stall=%b rs=%0d rt=%0d want 0/0/0/0", md_busy, stall, fwd_rs_D, fwd_rt_D);
    end
    tick();
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic [1:0] mds;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!hold) begin
        mds = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
        drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), mds,
              ($urandom_range(0, 7) == 0));
      end else begin
        #1;
      end
      n_cmp++;
      if (stall !== exp_stall() || fwd_rs_D !== exp_fwd(D_rs) || fwd_rt_D !== exp_fwd(D_rt) || md_busy !== exp_busy()) begin
        n_err++;
        $display("FAIL random cyc%0d got stall=%b rs=%0d rt=%0d busy=%b want %b/%0d/%0d/%b",
                 i, stall, fwd_rs_D, fwd_rt_D, md_busy, exp_stall(), exp_fwd(D_rs), exp_fwd(D_rt), exp_busy());
      end
      hold = exp_stall() && !reset;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    me_dst = 0; mm_dst = 0; mw_dst = 0; me_tnew = 0; mm_tnew = 0; me_md = 2'b00;
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_zero_dst();
    test_mult_mflo();
    test_back_to_back_div();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
